alarm_key_controller: RTL and testbench

ALARM_KEY_CONTROLLER -- requirements
Module: alarm_key_controller

---
 rtl/alarm_key_controller.sv | 185 ++++++++++++++++++
 tb/tb_alarm_key_controller.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alarm_key_controller.sv
// rtl/alarm_key_controller.sv - keypad entry FSM for alarm clock time/alarm setting
module alarm_key_controller #(
   parameter int NUM_DIGITS  = 4,
   parameter int NUM_ALARMS  = 2,
   parameter int TIMEOUT_SEC = 10,
   localparam int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk256,
   input  logic                  reset,
   input  logic                  one_second,
   input  logic [7:0]            key,
   output logic                  digit_shift,
   output logic [3:0]            digit_value,
   output logic [NUM_ALARMS-1:0] load_alarm,
   output logic                  load_new_time,
   output logic                  show_alarm,
   output logic [SEL_W-1:0]      alarm_sel,
   output logic                  entry_active,
   output logic                  entry_error
);
   localparam int CW = $clog2(NUM_DIGITS + 1);
   localparam logic [CW-1:0]    FULL      = CW'(NUM_DIGITS);
   localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_ALARMS - 1);
   localparam logic [7:0]       TO_RELOAD = 8'(TIMEOUT_SEC);
   localparam logic [7:0]       K_REL   = 8'hF0;
   localparam logic [7:0]       K_IDLE  = 8'h00;
   localparam logic [7:0]       K_STAR  = 8'h7C;
   localparam logic [7:0]       K_MINUS = 8'h7B;
   localparam logic [7:0]       K_PLUS  = 8'h79;

   typedef enum logic [3:0] {
      IDLE, SHIFT, HOLD, RELEASE, ENTRY, COMMIT_ALARM, COMMIT_TIME,
      SHOW_ALARM, SEL_RELEASE, ABORT
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      timeout_q, timeout_d;
   logic            commit_q, commit_d;
   logic            seen_q, seen_d;
   logic [SEL_W-1:0] sel_d;
   logic            shift_d, lnt_d, show_d, active_d, err_d, take_digit;
   logic [3:0]      value_d;
   logic [NUM_ALARMS-1:0] load_d;
   logic            dig_ok;
   logic [3:0]      dig_val;

   function automatic logic [4:0] decode_digit(input logic [7:0] k);
      case (k)
         8'h70: return 5'h10;
         8'h69: return 5'h11;
         8'h72: return 5'h12;
         8'h7A: return 5'h13;
         8'h6B: return 5'h14;
         8'h73: return 5'h15;
         8'h74: return 5'h16;
         8'h6C: return 5'h17;
         8'h75: return 5'h18;
         8'h7D: return 5'h19;
         default: return 5'h00;
      endcase
   endfunction

   assign {dig_ok, dig_val} = decode_digit(key);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      timeout_d  = timeout_q;
      commit_d   = commit_q;
      seen_d     = seen_q;
      sel_d      = alarm_sel;
      shift_d    = 1'b0;
      value_d    = 4'd0;
      load_d     = '0;
      lnt_d      = 1'b0;
      err_d      = 1'b0;
      take_digit = 1'b0;
      case (state_q)
         IDLE: begin
            seen_d   = 1'b0;
            commit_d = 1'b0;
            if (dig_ok) begin
               state_d    = SHIFT;
               take_digit = 1'b1;
            end else if (key == K_STAR) begin
               state_d = SHOW_ALARM;
            end else if (key == K_PLUS) begin
               state_d = SEL_RELEASE;
               sel_d   = (alarm_sel == LAST_SEL) ? '0 : alarm_sel + SEL_W'(1);
            end
         end
         SHIFT: state_d = HOLD;
         HOLD:  if (key == K_REL) state_d = RELEASE;
         RELEASE: begin
            // a release after a commit ends the entry instead of resuming it
            if (key == K_IDLE) begin
               if (commit_q) begin
                  state_d  = IDLE;
                  commit_d = 1'b0;
               end else begin
                  state_d   = ENTRY;
                  timeout_d = TO_RELOAD;
               end
            end
         end
         ENTRY: begin
            if (dig_ok) begin
               state_d    = SHIFT;
               take_digit = 1'b1;
            end else if (key == K_STAR || key == K_MINUS) begin
               state_d  = (key == K_STAR) ? COMMIT_ALARM : COMMIT_TIME;
               commit_d = 1'b1;
               count_d  = '0;
               if (count_q != FULL) err_d = 1'b1;
               else if (key == K_MINUS) lnt_d = 1'b1;
               else for (int i = 0; i < NUM_ALARMS; i++) load_d[i] = (alarm_sel == SEL_W'(i));
            end else if (timeout_q == 8'd0) begin
               state_d = ABORT;
               err_d   = 1'b1;
               count_d = '0;
            end else if (one_second) begin
               timeout_d = timeout_q - 8'd1;
            end
         end
         COMMIT_ALARM, COMMIT_TIME: state_d = HOLD;
         SHOW_ALARM, SEL_RELEASE: begin
            if (!seen_q) begin
               if (key == K_REL) seen_d = 1'b1;
            end else if (key == K_IDLE) begin
               state_d = IDLE;
               seen_d  = 1'b0;
            end
         end
         ABORT: state_d = IDLE;
         default: begin
            state_d  = IDLE;
            count_d  = '0;
            commit_d = 1'b0;
            seen_d   = 1'b0;
         end
      endcase
      // digits beyond a full entry still walk through SHIFT but are dropped
      if (take_digit && count_q < FULL) begin
         shift_d = 1'b1;
         value_d = dig_val;
         count_d = count_q + CW'(1);
      end
      show_d   = (state_d == SHOW_ALARM) && !seen_d;
      active_d = (state_d == SHIFT || state_d == HOLD || state_d == RELEASE ||
                  state_d == ENTRY) && (count_d != '0);
   end

   always_ff @(posedge clk256 or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         count_q       <= '0;
         timeout_q     <= 8'd0;
         commit_q      <= 1'b0;
         seen_q        <= 1'b0;
         alarm_sel     <= '0;
         digit_shift   <= 1'b0;
         digit_value   <= 4'd0;
         load_alarm    <= '0;
         load_new_time <= 1'b0;
         show_alarm    <= 1'b0;
         entry_active  <= 1'b0;
         entry_error   <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         timeout_q     <= timeout_d;
         commit_q      <= commit_d;
         seen_q        <= seen_d;
         alarm_sel     <= sel_d;
         digit_shift   <= shift_d;
         digit_value   <= value_d;
         load_alarm    <= load_d;
         load_new_time <= lnt_d;
         show_alarm    <= show_d;
         entry_active  <= active_d;
         entry_error   <= err_d;
      end
   end
endmodule

// File: tb/tb_alarm_key_controller.sv
// tb/tb_alarm_key_controller.sv - directed self-checking bench for alarm_key_controller
module tb_alarm_key_controller;
   logic       clk256 = 1'b0;
   logic       reset = 1'b1;
   logic       one_second = 1'b0;
   logic [7:0] key = 8'h00;
   logic       digit_shift, load_new_time, show_alarm, entry_active, entry_error;
   logic [3:0] digit_value;
   logic [1:0] load_alarm;
   logic [0:0] alarm_sel;

   alarm_key_controller #(.NUM_DIGITS(4), .NUM_ALARMS(2), .TIMEOUT_SEC(10)) dut (
      .clk256(clk256), .reset(reset), .one_second(one_second), .key(key),
      .digit_shift(digit_shift), .digit_value(digit_value), .load_alarm(load_alarm),
      .load_new_time(load_new_time), .show_alarm(show_alarm), .alarm_sel(alarm_sel),
      .entry_active(entry_active), .entry_error(entry_error));

   always #5 clk256 = ~clk256;

   localparam logic [7:0] K_STAR = 8'h7C, K_MINUS = 8'h7B, K_PLUS = 8'h79;
   logic [7:0] kp [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

   int checks = 0, failures = 0;
   int n_shift = 0, n_lnt = 0, n_la0 = 0, n_la1 = 0, n_err = 0, n_multi = 0;
   int b_shift, b_lnt, b_la0, b_la1, b_err;
   logic [31:0] word = '0;
   int show_low;

   always @(negedge clk256) begin
      if (digit_shift) begin
         n_shift <= n_shift + 1;
         word    <= {word[27:0], digit_value};
      end
      if (load_new_time) n_lnt <= n_lnt + 1;
      if (load_alarm[0]) n_la0 <= n_la0 + 1;
      if (load_alarm[1]) n_la1 <= n_la1 + 1;
      if (entry_error) n_err <= n_err + 1;
      if (int'(digit_shift) + $countones(load_alarm) + int'(load_new_time) + int'(entry_error) > 1)
         n_multi <= n_multi + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk256);
   endtask

   task automatic press(input logic [7:0] code);
      key = code;  tick(2);
      key = 8'hF0; tick(2);
      key = code;  tick(2);
      key = 8'h00; tick(3);
   endtask

   task automatic snap();
      b_shift = n_shift; b_lnt = n_lnt; b_la0 = n_la0; b_la1 = n_la1; b_err = n_err;
   endtask

   task automatic pulse_second();
      one_second = 1'b1; tick(1);
      one_second = 1'b0; tick(1);
   endtask

   initial begin
      tick(3);
      check_eq("rst_outputs", {digit_shift, digit_value, load_alarm, load_new_time,
               show_alarm, alarm_sel, entry_active, entry_error}, 32'd0);
      reset = 1'b0;
      tick(2);

      snap();
      press(kp[1]);
      check_eq("entry_active_after_digit", entry_active, 1);
      press(kp[2]); press(kp[3]); press(kp[4]);
      press(K_MINUS);
      check_eq("time_shift_count", n_shift - b_shift, 4);
      check_eq("time_digits", word[15:0], 16'h1234);
      check_eq("time_load", n_lnt - b_lnt, 1);
      check_eq("time_no_error", n_err - b_err, 0);
      check_eq("time_no_alarm_load", (n_la0 - b_la0) + (n_la1 - b_la1), 0);
      check_eq("time_idle_inactive", entry_active, 0);

      snap();
      press(K_PLUS);
      check_eq("sel_advance", alarm_sel, 1);
      press(kp[0]); press(kp[7]); press(kp[3]); press(kp[0]);
      press(K_STAR);
      check_eq("alarm_digits", word[15:0], 16'h0730);
      check_eq("alarm_slot1_load", n_la1 - b_la1, 1);
      check_eq("alarm_slot0_quiet", n_la0 - b_la0, 0);
      check_eq("alarm_no_error", n_err - b_err, 0);

      snap();
      press(kp[5]); press(kp[9]);
      press(K_STAR);
      check_eq("short_shift_count", n_shift - b_shift, 2);
      check_eq("short_no_load", (n_la0 - b_la0) + (n_la1 - b_la1) + (n_lnt - b_lnt), 0);
      check_eq("short_error", n_err - b_err, 1);

      snap();
      press(kp[8]);
      repeat (9) pulse_second();
      tick(5);
      check_eq("timeout9_still_entry", entry_active, 1);
      check_eq("timeout9_no_error", n_err - b_err, 0);
      pulse_second();
      tick(4);
      check_eq("timeout10_error", n_err - b_err, 1);
      check_eq("timeout10_inactive", entry_active, 0);
      key = K_STAR; tick(2);
      check_eq("timeout10_back_idle", show_alarm, 1);
      key = 8'hF0; tick(2);
      key = 8'h00; tick(3);

      snap();
      press(kp[6]); press(kp[7]); press(kp[8]); press(kp[9]); press(kp[5]);
      check_eq("overflow_shift_count", n_shift - b_shift, 4);
      check_eq("overflow_digits", word[15:0], 16'h6789);
      press(K_STAR);
      check_eq("overflow_alarm_load", n_la1 - b_la1, 1);
      check_eq("overflow_no_error", n_err - b_err, 0);

      key = K_STAR; tick(1);
      show_low = 0;
      for (int i = 0; i < 99; i++) begin
         tick(1);
         if (!show_alarm) show_low++;
      end
      check_eq("show_held_cycles_low", show_low, 0);
      key = 8'hF0; tick(2);
      check_eq("show_drop_on_f0", show_alarm, 0);
      key = 8'h00; tick(3);
      press(K_PLUS);
      check_eq("sel_wrap", alarm_sel, 0);

      press(K_PLUS);
      snap();
      press(kp[1]); press(kp[2]); press(kp[3]);
      reset = 1'b1; tick(2);
      check_eq("midreset_outputs", {digit_shift, load_alarm, load_new_time, show_alarm,
               alarm_sel, entry_active, entry_error}, 32'd0);
      reset = 1'b0; tick(2);
      key = K_STAR; tick(2);
      check_eq("midreset_star_from_idle", show_alarm, 1);
      key = 8'hF0; tick(2);
      key = 8'h00; tick(3);
      check_eq("midreset_no_load", (n_la0 - b_la0) + (n_la1 - b_la1) + (n_lnt - b_lnt), 0);
      check_eq("midreset_no_error", n_err - b_err, 0);

      check_eq("pulse_exclusive", n_multi, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
